// File: rtl/multicycle_control.sv
// multicycle_control: FSM control unit for the multicycle MIPS core with memory watchdog.
// Define MULTICYCLE_CONTROL_RETIRE_CNT_EN to add the retired-instruction counter output.
module multicycle_control #(
    parameter int ALUFN_W = 5,
    parameter int TIMEOUT = 255,
    parameter int TMO_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic [5:0]         func,
    input  logic               mem_ready,
    output logic [ALUFN_W-1:0] alufn,
    output logic               f_memwrite,
    output logic               f_regwrite,
    output logic               f_bne,
    output logic               f_beq,
    output logic               f_zeroextend,
    output logic               f_dst_rt_rd,
    output logic               f_shiftval,
    output logic               f_alusrc,
    output logic               f_mem2reg,
    output logic               f_jump1,
    output logic               f_jump2,
    output logic               pc_write,
    output logic               ir_write,
    output logic               mem_req,
    output logic               illegal,
    output logic               bus_err,
    output logic [2:0]         state
`ifdef MULTICYCLE_CONTROL_RETIRE_CNT_EN
    ,
    output logic [31:0]        retired
`endif
);
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        JUMP   = 3'd5,
        TRAP   = 3'd6
    } state_t;
    typedef struct packed {
        logic [4:0] alufn;
        logic       bne;
        logic       beq;
        logic       zext;
        logic       rtrd;
        logic       shv;
        logic       alusrc;
        logic       m2r;
        logic       j1;
        logic       j2;
        logic       lw;
        logic       sw;
        logic       jal;
    } ctrl_t;
    state_t     cur, nxt;
    ctrl_t      word, dec;
    logic       legal;
    logic [TMO_W-1:0] cnt;
    logic       in_mem, waiting, tmo, run, flags_on;
    assign state   = cur;
    assign in_mem  = cur == FETCH || cur == MEM;
    assign waiting = in_mem && !mem_ready;
    // Trap in the wait cycle that would bring the counter to TIMEOUT; a ready in that cycle wins.
    assign tmo     = (TIMEOUT != 0) && waiting && (32'(cnt) == TIMEOUT - 1);
    always_comb begin
        dec   = '0;
        legal = 1'b1;
        case (opcode)
            6'b000000: begin
                dec.rtrd = 1'b1;
                case (func)
                    6'b100000: dec.alufn = 5'b00001;
                    6'b100010: dec.alufn = 5'b10001;
                    6'b100100: dec.alufn = 5'b00000;
                    6'b100101: dec.alufn = 5'b00100;
                    6'b100110: dec.alufn = 5'b01000;
                    6'b101010: dec.alufn = 5'b10011;
                    6'b000000: begin dec.alufn = 5'b00010; dec.shv = 1'b1; end
                    6'b000100: dec.alufn = 5'b00010;
                    6'b000011: begin dec.alufn = 5'b01010; dec.shv = 1'b1; end
                    6'b000010: begin dec.alufn = 5'b01110; dec.shv = 1'b1; end
                    6'b000110: dec.alufn = 5'b01110;
                    6'b001000: dec.j2 = 1'b1;
                    default:   legal = 1'b0;
                endcase
            end
            6'b001000: begin dec.alufn = 5'b00001; dec.alusrc = 1'b1; end
            6'b001010: begin dec.alufn = 5'b10011; dec.alusrc = 1'b1; end
            6'b001100: begin dec.alufn = 5'b00000; dec.alusrc = 1'b1; dec.zext = 1'b1; end
            6'b001101: begin dec.alufn = 5'b00100; dec.alusrc = 1'b1; dec.zext = 1'b1; end
            6'b001110: begin dec.alufn = 5'b01000; dec.alusrc = 1'b1; dec.zext = 1'b1; end
            6'b100011: begin dec.alufn = 5'b00001; dec.alusrc = 1'b1; dec.m2r = 1'b1; dec.lw = 1'b1; end
            6'b101011: begin dec.alufn = 5'b00001; dec.alusrc = 1'b1; dec.sw = 1'b1; end
            6'b000100: begin dec.alufn = 5'b10001; dec.beq = 1'b1; end
            6'b000101: begin dec.alufn = 5'b10001; dec.bne = 1'b1; end
            6'b000010: dec.j1 = 1'b1;
            6'b000011: begin dec.j1 = 1'b1; dec.j2 = 1'b1; dec.jal = 1'b1; end
            default:   legal = 1'b0;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cur <= FETCH;
        else cur <= nxt;
    end
    always_comb begin
        nxt = cur;
        case (cur)
            FETCH:    nxt = mem_ready ? DECODE : tmo ? TRAP : FETCH;
            DECODE:   nxt = !legal ? TRAP : (dec.j1 || dec.j2) ? JUMP : EXEC;
            EXEC:     nxt = (word.beq || word.bne) ? FETCH : (word.lw || word.sw) ? MEM : WB;
            MEM:      nxt = mem_ready ? (word.sw ? FETCH : WB) : tmo ? TRAP : MEM;
            WB, JUMP: nxt = FETCH;
            TRAP:     nxt = TRAP;
            default:  nxt = FETCH;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word    <= '0;
            cnt     <= '0;
            illegal <= 1'b0;
            bus_err <= 1'b0;
        end else begin
            if (cur == DECODE) word <= legal ? dec : '0;
            cnt     <= (nxt != cur && (nxt == FETCH || nxt == MEM)) ? '0 : waiting ? cnt + TMO_W'(1) : cnt;
            illegal <= illegal || (cur == DECODE && !legal);
            bus_err <= bus_err || tmo;
        end
    end
    // Outputs are gated by reset so an in-flight strobe drops as soon as reset rises.
    always_comb begin
        run          = !reset;
        flags_on     = run && (cur == EXEC || cur == MEM || cur == WB || cur == JUMP);
        alufn        = flags_on ? ALUFN_W'(word.alufn) : '0;
        f_bne        = flags_on && word.bne;
        f_beq        = flags_on && word.beq;
        f_zeroextend = flags_on && word.zext;
        f_dst_rt_rd  = flags_on && word.rtrd;
        f_shiftval   = flags_on && word.shv;
        f_alusrc     = flags_on && word.alusrc;
        f_mem2reg    = flags_on && word.m2r;
        f_jump1      = flags_on && word.j1;
        f_jump2      = flags_on && word.j2;
        mem_req      = run && in_mem;
        ir_write     = run && cur == FETCH && mem_ready;
        f_memwrite   = run && cur == MEM && word.sw;
        f_regwrite   = run && (cur == WB || (cur == JUMP && word.jal));
        pc_write     = run && ((cur == EXEC && (word.beq || word.bne)) ||
                               (cur == MEM && mem_ready && word.sw) || cur == WB || cur == JUMP);
    end
`ifdef MULTICYCLE_CONTROL_RETIRE_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) retired <= '0;
        else if (pc_write) retired <= retired + 32'd1;
    end
`endif
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: table-driven scoreboard bench for multicycle_control (TIMEOUT=4).
module tb_multicycle_control;
    logic       clk = 1'b0;
    logic       reset, mem_ready;
    logic [5:0] opcode, func;
    logic [4:0] alufn;
    logic       f_memwrite, f_regwrite, f_bne, f_beq, f_zeroextend, f_dst_rt_rd;
    logic       f_shiftval, f_alusrc, f_mem2reg, f_jump1, f_jump2;
    logic       pc_write, ir_write, mem_req, illegal, bus_err;
    logic [2:0] state;
`ifdef MULTICYCLE_CONTROL_RETIRE_CNT_EN
    logic [31:0] retired;
`endif
    multicycle_control #(.ALUFN_W(5), .TIMEOUT(4), .TMO_W(8)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .func(func), .mem_ready(mem_ready),
        .alufn(alufn), .f_memwrite(f_memwrite), .f_regwrite(f_regwrite), .f_bne(f_bne),
        .f_beq(f_beq), .f_zeroextend(f_zeroextend), .f_dst_rt_rd(f_dst_rt_rd),
        .f_shiftval(f_shiftval), .f_alusrc(f_alusrc), .f_mem2reg(f_mem2reg),
        .f_jump1(f_jump1), .f_jump2(f_jump2), .pc_write(pc_write), .ir_write(ir_write),
        .mem_req(mem_req), .illegal(illegal), .bus_err(bus_err), .state(state)
`ifdef MULTICYCLE_CONTROL_RETIRE_CNT_EN
        , .retired(retired)
`endif
    );
    always #5 clk = ~clk;
    typedef enum int {K_ALU, K_LW, K_SW, K_BR, K_JMP, K_JAL} kind_t;
    // fl order: bne beq zext rtrd shv alusrc m2r j1 j2
    typedef struct packed {
        logic [2:0] st;
        logic [4:0] alufn;
        logic       mw, rw, pw, iw, mr;
        logic [8:0] fl;
        logic       ill, berr;
    } obs_t;
    typedef struct {
        string      name;
        logic [5:0] op, fn;
        int         fw, mw;
        kind_t      kind;
        logic [4:0] alufn;
        logic [8:0] fl;
    } vec_t;
    typedef struct {
        string name;
        obs_t  o;
    } exp_t;
    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0, errors = 0;
    int   sw_i;
    function automatic obs_t sample();
        return {state, alufn, f_memwrite, f_regwrite, pc_write, ir_write, mem_req,
                f_bne, f_beq, f_zeroextend, f_dst_rt_rd, f_shiftval, f_alusrc, f_mem2reg,
                f_jump1, f_jump2, illegal, bus_err};
    endfunction
    function automatic void check(string name, obs_t got, obs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endfunction
    function automatic vec_t mk(string name, logic [5:0] op, logic [5:0] fn, int fw, int mw,
                                kind_t kind, logic [4:0] a, logic [8:0] fl);
        vec_t v;
        v.name = name; v.op = op; v.fn = fn; v.fw = fw; v.mw = mw;
        v.kind = kind; v.alufn = a; v.fl = fl;
        return v;
    endfunction
    function automatic obs_t ex(vec_t v, logic [2:0] st, bit mw, bit rw, bit pw, bit iw, bit mr);
        return {st, v.alufn, mw, rw, pw, iw, mr, v.fl, 1'b0, 1'b0};
    endfunction
    function automatic obs_t bare(logic [2:0] st, bit mr, bit iw, bit ill, bit be);
        return {st, 5'd0, 1'b0, 1'b0, 1'b0, iw, mr, 9'd0, ill, be};
    endfunction
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.name, sample(), e.o);
        end
    end
    task automatic cyc(bit rdy, string name, obs_t e);
        exp_t x;
        mem_ready = rdy;
        x.name = name;
        x.o = e;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset(string name);
        mem_ready = 1'b1;
        reset = 1'b1;
        #2;
        check(name, sample(), '0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask
    task automatic run_vec(vec_t v);
        opcode = v.op;
        func = v.fn;
        repeat (v.fw) cyc(0, {v.name, ":fetch_wait"}, bare(0, 1, 0, 0, 0));
        cyc(1, {v.name, ":fetch"}, bare(0, 1, 1, 0, 0));
        cyc(1, {v.name, ":decode"}, bare(1, 0, 0, 0, 0));
        case (v.kind)
            K_ALU: begin
                cyc(1, {v.name, ":exec"}, ex(v, 2, 0, 0, 0, 0, 0));
                cyc(1, {v.name, ":wb"}, ex(v, 4, 0, 1, 1, 0, 0));
            end
            K_LW: begin
                cyc(1, {v.name, ":exec"}, ex(v, 2, 0, 0, 0, 0, 0));
                repeat (v.mw) cyc(0, {v.name, ":mem_wait"}, ex(v, 3, 0, 0, 0, 0, 1));
                cyc(1, {v.name, ":mem"}, ex(v, 3, 0, 0, 0, 0, 1));
                cyc(1, {v.name, ":wb"}, ex(v, 4, 0, 1, 1, 0, 0));
            end
            K_SW: begin
                cyc(1, {v.name, ":exec"}, ex(v, 2, 0, 0, 0, 0, 0));
                repeat (v.mw) cyc(0, {v.name, ":mem_wait"}, ex(v, 3, 1, 0, 0, 0, 1));
                cyc(1, {v.name, ":mem"}, ex(v, 3, 1, 0, 1, 0, 1));
            end
            K_BR:  cyc(1, {v.name, ":exec"}, ex(v, 2, 0, 0, 1, 0, 0));
            K_JMP: cyc(1, {v.name, ":jump"}, ex(v, 5, 0, 0, 1, 0, 0));
            K_JAL: cyc(1, {v.name, ":jump"}, ex(v, 5, 0, 1, 1, 0, 0));
            default: check({v.name, ":kind"}, sample(), ~sample());
        endcase
    endtask
    task automatic do_ill(string name, logic [5:0] op, logic [5:0] fn);
        opcode = op;
        func = fn;
        cyc(1, {name, ":fetch"}, bare(0, 1, 1, 0, 0));
        cyc(1, {name, ":decode"}, bare(1, 0, 0, 0, 0));
        cyc(1, {name, ":trap"}, bare(6, 0, 0, 1, 0));
        cyc(0, {name, ":trap"}, bare(6, 0, 0, 1, 0));
        cyc(1, {name, ":trap"}, bare(6, 0, 0, 1, 0));
        do_reset({name, ":reset_clears"});
    endtask
    initial begin
        reset = 1'b1;
        mem_ready = 1'b1;
        opcode = '0;
        func = '0;
        vecs.push_back(mk("add",  6'h00, 6'h20, 0, 0, K_ALU, 5'b00001, 9'b000100000));
        vecs.push_back(mk("sub",  6'h00, 6'h22, 0, 0, K_ALU, 5'b10001, 9'b000100000));
        vecs.push_back(mk("and",  6'h00, 6'h24, 0, 0, K_ALU, 5'b00000, 9'b000100000));
        vecs.push_back(mk("or",   6'h00, 6'h25, 0, 0, K_ALU, 5'b00100, 9'b000100000));
        vecs.push_back(mk("xor",  6'h00, 6'h26, 0, 0, K_ALU, 5'b01000, 9'b000100000));
        vecs.push_back(mk("slt",  6'h00, 6'h2a, 0, 0, K_ALU, 5'b10011, 9'b000100000));
        vecs.push_back(mk("sll",  6'h00, 6'h00, 0, 0, K_ALU, 5'b00010, 9'b000110000));
        vecs.push_back(mk("sllv", 6'h00, 6'h04, 0, 0, K_ALU, 5'b00010, 9'b000100000));
        vecs.push_back(mk("sra",  6'h00, 6'h03, 0, 0, K_ALU, 5'b01010, 9'b000110000));
        vecs.push_back(mk("srl",  6'h00, 6'h02, 0, 0, K_ALU, 5'b01110, 9'b000110000));
        vecs.push_back(mk("srlv", 6'h00, 6'h06, 0, 0, K_ALU, 5'b01110, 9'b000100000));
        vecs.push_back(mk("jr",   6'h00, 6'h08, 0, 0, K_JMP, 5'b00000, 9'b000100001));
        vecs.push_back(mk("addi", 6'h08, 6'h3f, 0, 0, K_ALU, 5'b00001, 9'b000001000));
        vecs.push_back(mk("slti", 6'h0a, 6'h3f, 0, 0, K_ALU, 5'b10011, 9'b000001000));
        vecs.push_back(mk("andi", 6'h0c, 6'h3f, 0, 0, K_ALU, 5'b00000, 9'b001001000));
        vecs.push_back(mk("ori",  6'h0d, 6'h3f, 0, 0, K_ALU, 5'b00100, 9'b001001000));
        vecs.push_back(mk("xori", 6'h0e, 6'h3f, 0, 0, K_ALU, 5'b01000, 9'b001001000));
        vecs.push_back(mk("lw",   6'h23, 6'h3f, 0, 3, K_LW,  5'b00001, 9'b000001100));
        sw_i = vecs.size();
        vecs.push_back(mk("sw",   6'h2b, 6'h3f, 0, 2, K_SW,  5'b00001, 9'b000001000));
        vecs.push_back(mk("beq",  6'h04, 6'h3f, 0, 0, K_BR,  5'b10001, 9'b010000000));
        vecs.push_back(mk("bne",  6'h05, 6'h3f, 0, 0, K_BR,  5'b10001, 9'b100000000));
        vecs.push_back(mk("j",    6'h02, 6'h3f, 0, 0, K_JMP, 5'b00000, 9'b000000010));
        vecs.push_back(mk("jal",  6'h03, 6'h3f, 0, 0, K_JAL, 5'b00000, 9'b000000011));
        vecs.push_back(mk("add_ready_at_limit", 6'h00, 6'h20, 3, 0, K_ALU, 5'b00001, 9'b000100000));
        vecs.push_back(mk("lw_nowait", 6'h23, 6'h00, 0, 0, K_LW, 5'b00001, 9'b000001100));
        vecs.push_back(mk("sw_nowait", 6'h2b, 6'h00, 0, 0, K_SW, 5'b00001, 9'b000001000));
        @(posedge clk);
        #1;
        do_reset("reset_state");
        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);
        do_ill("ill_op3f", 6'h3f, 6'h20);
        do_ill("ill_addu", 6'h00, 6'h21);
        repeat (4) cyc(0, "tmo:wait", bare(0, 1, 0, 0, 0));
        cyc(1, "tmo:trap", bare(6, 0, 0, 0, 1));
        cyc(0, "tmo:trap", bare(6, 0, 0, 0, 1));
        do_reset("tmo:reset_clears");
        opcode = vecs[sw_i].op;
        func = vecs[sw_i].fn;
        cyc(1, "rst_mem:fetch", bare(0, 1, 1, 0, 0));
        cyc(1, "rst_mem:decode", bare(1, 0, 0, 0, 0));
        cyc(1, "rst_mem:exec", ex(vecs[sw_i], 2, 0, 0, 0, 0, 0));
        cyc(0, "rst_mem:mem", ex(vecs[sw_i], 3, 1, 0, 0, 0, 1));
        mem_ready = 1'b0;
        #1;
        check("rst_mem:before", sample(), ex(vecs[sw_i], 3, 1, 0, 0, 0, 1));
        reset = 1'b1;
        #1;
        check("rst_mem:abort", sample(), '0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_mem:release", sample(), bare(0, 1, 0, 0, 0));
        @(posedge clk);
        #1;
        run_vec(vecs[0]);
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
